uart_tx_buf: RTL
================

# uart_tx_buf

Buffered 8N1 UART transmitter: one start bit, 8 data bits LSB-first, one stop bit, no parity. It is the transmit counterpart of the team's UART receiver and shares its `CLKS_PER_BIT` convention. A small synchronous FIFO decouples the byte producer from the serial line, so host logic can burst several bytes without waiting for each frame. The block sits between the command/response logic and the board's TX pin or IR modulator.

## Interface
- `CLKS_PER_BIT`, 104 — clock cycles per bit, equal to (clock frequency)/(baud). Must be ≥ 2.
- `FIFO_DEPTH`, 4 — byte FIFO entries. Power of two, ≥ 2.
- `i_Clock` in 1 — sole clock; all logic on the rising edge.
- `i_Rst` in 1 — reset, synchronous, active-high.
- `i_Tx_DV` in 1 — byte-valid strobe; a write is accepted when `i_Tx_DV && o_Tx_Ready`.
- `i_Tx_Byte` in 8 — byte to send; sampled on the accept edge.
- `o_Tx_Ready` in/out: out 1 — FIFO not full; registered.
- `o_Tx_Serial` out 1 — serial line; idles high.
- `o_Tx_Active` out 1 — high from the start bit through the end of the stop bit.
- `o_Tx_Done` out 1 — one-cycle pulse after each stop bit completes.
- `o_Fifo_Count` out $clog2(FIFO_DEPTH)+1 — number of bytes held in the FIFO, excluding the byte in the shift register.

## Operation
- States: IDLE, START, DATA, STOP, CLEANUP.
- **IDLE.** Line high. If the FIFO is non-empty: pop the head into an 8-bit shift register, clear the bit counter and bit index, go to START.
- **START.** Drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA.** Drive `shift[bit_index]` for `CLKS_PER_BIT` cycles per bit, indices 0 to 7. After index 7 completes, go to STOP.
- **STOP.** Drive 1 for `CLKS_PER_BIT` cycles, then go to CLEANUP.
- **CLEANUP.** Line high. Pulse `o_Tx_Done` for exactly this cycle, then go to IDLE.
- Bit counter counts 0 to `CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Width is $clog2(`CLKS_PER_BIT`). Bit index is 3 bits.
- The FIFO push is ignored when full. No overwrite, no error flag.
- Simultaneous push and pop: both take effect and the count is unchanged. On an empty FIFO a push is visible to IDLE only on the next cycle; there is no bypass.
- `i_Tx_Byte` is ignored when `i_Tx_DV` is low.
- Reset at any time:
  - State goes to IDLE and the FIFO empties.
  - On the next cycle, `o_Tx_Serial` = 1, `o_Tx_Active` = 0, `o_Tx_Done` = 0, `o_Tx_Ready` = 1, `o_Fifo_Count` = 0.
  - An aborted frame produces no Done pulse.

## Timing
- Byte accepted at edge N into an idle block with an empty FIFO:
  - FIFO holds the byte after N+1.
  - Pop at N+1.
  - `o_Tx_Serial` falls after N+2.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles of start + data + stop.
- `o_Tx_Active` rises with the start bit and falls after the last stop-bit cycle, i.e. in the same cycle `o_Tx_Done` goes high.
- Back-to-back frames: the next start bit begins 2 cycles after the stop bit ends (CLKS_PER_BIT stop cycles, then CLEANUP, then IDLE pop, then START). The line stays high during the gap.
- `o_Tx_Ready` is low in the cycle after the accept that makes the count reach `FIFO_DEPTH`. It returns high in the cycle after a pop.
- Outputs are registered.

## Structure
- Shared package `uart_pkg`, also used by the receiver:
  - State encodings: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4, all 3-bit.
  - Frame constants: data bits 8, stop bits 1.
- Sub-module `uart_tx_fifo`:
  - Synchronous, single-clock, parameterised on `FIFO_DEPTH` and width 8.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout shows the head word combinationally (first-word-fall-through), so IDLE can load it on the pop edge.
- The top level holds the FSM, bit counter, shift register and output registers.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=4. Send 0x55.
  - Required: `o_Tx_Serial` = 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles, starting 2 cycles after accept.
  - Required: one `o_Tx_Done` pulse, with `o_Tx_Active` high for exactly 40 cycles.
- **Loopback.** Connect `o_Tx_Serial` to the team UART receiver with the same `CLKS_PER_BIT`. Send 0xA5, 0x3C, 0xFF, 0x00 in a burst.
  - Required: the receiver outputs the same four bytes in order, with four Done pulses.
  - Required: each inter-frame high gap is exactly 2 cycles.
- **Overflow.** `FIFO_DEPTH`=4. Hold `i_Tx_DV` high for 7 cycles with bytes 0x01 to 0x07.
  - Required: 0x01 is popped; 0x02 to 0x05 fill the FIFO; `o_Tx_Ready` goes low.
  - Required: 0x06 and 0x07 are dropped; the line carries exactly 0x01 to 0x05.
- **Simultaneous push/pop.** Push in the same cycle IDLE pops, with `o_Fifo_Count`=2.
  - Required: the count stays 2 and the next byte order is preserved.
- **Reset mid-frame.** Assert `i_Rst` for 1 cycle during data bit 3 of 0x00, with 2 bytes queued.
  - Required: the next cycle shows line high, count 0, Ready 1, no Done pulse.
  - Required: no further frames are sent.
- **Idle hold.** After reset with no `i_Tx_DV` for 1000 cycles.
  - Required: `o_Tx_Serial` stays 1 and `o_Tx_Active`/`o_Tx_Done` stay 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with first-word-fall-through head, so the
// transmitter can load dout on the same edge it pops.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// serialiser. All serial-side outputs are registered from the FSM state.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | line high; pop FIFO head into shifter if any
// START   | start bit (0) for CLKS_PER_BIT cycles
// DATA    | data bits 0..7, LSB first
// STOP    | stop bit (1) for CLKS_PER_BIT cycles
// CLEANUP | one cycle, raises the Done pulse
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk   (i_Clock),
    .rst   (i_Rst),
    .push  (i_Tx_DV),
    .pop   (fifo_pop),
    .din   (i_Tx_Byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_Fifo_Count)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CLEANUP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs lag the state by one cycle; frame timing is unchanged by the lag.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      ST_DATA: begin
        serial_d = shift_q[idx_q];
        active_d = 1'b1;
      end
      ST_STOP:    active_d = 1'b1;
      ST_CLEANUP: done_d   = 1'b1;
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule
